// File: rtl/pe_array_sequencer.sv
// Microprogrammed step sequencer driving a pe_array command/shift/ack interface.
// Optional watchdog on WAIT_RDY enabled by defining PE_SEQ_WATCHDOG_EN.
module pe_array_sequencer #(
  parameter int unsigned               command_width  = 4,
  parameter int unsigned               PROG_DEPTH     = 16,
  parameter int unsigned               ADDR_W         = 4,
  parameter int unsigned               REPEAT_WIDTH   = 8,
  parameter logic [command_width-1:0]  NOP_CMD        = '0,
  parameter int unsigned               TIMEOUT_CYCLES = 255
) (
  input  logic                                    CLK,
  input  logic                                    RST,
  input  logic                                    prog_we,
  input  logic [ADDR_W-1:0]                       prog_addr,
  input  logic [command_width+2+REPEAT_WIDTH-1:0] prog_data,
  input  logic [ADDR_W:0]                         prog_len,
  input  logic                                    start,
  input  logic                                    array_ready,
  output logic [command_width-1:0]                command_to_execute,
  output logic [1:0]                              shift_direction,
  output logic                                    array_ack,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    error,
  output logic [ADDR_W-1:0]                       step_idx
);

  localparam int unsigned DataW = command_width + 2 + REPEAT_WIDTH;
  localparam logic [ADDR_W:0] LenMax = (ADDR_W + 1)'(PROG_DEPTH);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StFetch = 3'd1;
  localparam logic [2:0] StIssue = 3'd2;
  localparam logic [2:0] StWait  = 3'd3;
  localparam logic [2:0] StAck   = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  logic [DataW-1:0] mem_q [PROG_DEPTH];

  logic [2:0]               state_q, state_d;
  logic [ADDR_W:0]          len_q, len_d;
  logic [ADDR_W-1:0]        idx_q, idx_d;
  logic [command_width-1:0] cmd_q, cmd_d;
  logic [1:0]               dir_q, dir_d;
  logic [REPEAT_WIDTH-1:0]  rep_q, rep_d;
  logic                     err_q, err_d;
  logic [command_width-1:0] cmd_out_q, cmd_out_d;
  logic [1:0]               dir_out_q, dir_out_d;
  logic                     ack_q, ack_d, busy_q, busy_d, done_q, done_d;
  logic                     drive;

  logic [DataW-1:0]         ent;
  logic [command_width-1:0] ent_cmd;
  logic [1:0]               ent_dir;
  logic [REPEAT_WIDTH-1:0]  ent_rep;

`ifdef PE_SEQ_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WdW-1:0] wd_q, wd_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  assign ent     = mem_q[idx_q];
  assign ent_cmd = ent[DataW-1 -: command_width];
  assign ent_dir = ent[REPEAT_WIDTH +: 2];
  assign ent_rep = ent[REPEAT_WIDTH-1:0];

  // Program store has no reset so a loaded program survives RST.
  always_ff @(posedge CLK) begin
    if (prog_we && !busy_q) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cmd_d   = cmd_q;
    dir_d   = dir_q;
    rep_d   = rep_q;
    err_d   = err_q;
`ifdef PE_SEQ_WATCHDOG_EN
    wd_d    = '0;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          err_d = 1'b0;
          if (prog_len == '0) begin
            state_d = StDone;
          end else begin
            len_d   = (prog_len > LenMax) ? LenMax : prog_len;
            idx_d   = '0;
            state_d = StFetch;
          end
        end
      end
      StFetch: begin
        cmd_d   = ent_cmd;
        dir_d   = ent_dir;
        rep_d   = ent_rep;
        state_d = StIssue;
      end
      // Ready is deliberately ignored here so a stale ready cannot ack a new command.
      StIssue: state_d = StWait;
      StWait: begin
        if (array_ready) begin
          state_d = StAck;
`ifdef PE_SEQ_WATCHDOG_EN
        end else if (wd_q == WdW'(TIMEOUT_CYCLES - 1)) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
`endif
        end
      end
      StAck: begin
        if (rep_q != '0) begin
          rep_d   = rep_q - 1'b1;
          state_d = StIssue;
        end else if ({1'b0, idx_q} == len_q - 1'b1) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StFetch;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they change only on the clock edge.
    drive     = (state_d == StIssue) || (state_d == StWait);
    cmd_out_d = drive ? cmd_d : NOP_CMD;
    dir_out_d = drive ? dir_d : 2'b00;
    ack_d     = (state_d == StAck);
    done_d    = (state_d == StDone);
    busy_d    = (state_d == StFetch) || drive || (state_d == StAck);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      len_q     <= '0;
      idx_q     <= '0;
      cmd_q     <= NOP_CMD;
      dir_q     <= 2'b00;
      rep_q     <= '0;
      err_q     <= 1'b0;
      cmd_out_q <= NOP_CMD;
      dir_out_q <= 2'b00;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef PE_SEQ_WATCHDOG_EN
      wd_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      cmd_q     <= cmd_d;
      dir_q     <= dir_d;
      rep_q     <= rep_d;
      err_q     <= err_d;
      cmd_out_q <= cmd_out_d;
      dir_out_q <= dir_out_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef PE_SEQ_WATCHDOG_EN
      wd_q      <= wd_d;
`endif
    end
  end

  assign command_to_execute = cmd_out_q;
  assign shift_direction    = dir_out_q;
  assign array_ack          = ack_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign error              = err_q;
  assign step_idx           = idx_q;

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Bench for pe_array_sequencer: a trace model expands the loaded program into the
// expected per-cycle outputs; directed runs plus literal ack/latency counts pin it.
module tb_pe_array_sequencer;

  logic        CLK, RST, prog_we, start, array_ready;
  logic [3:0]  prog_addr;
  logic [13:0] prog_data;
  logic [4:0]  prog_len;
  logic [3:0]  command_to_execute;
  logic [1:0]  shift_direction;
  logic        array_ack, busy, done, error;
  logic [3:0]  step_idx;

  pe_array_sequencer #(
    .command_width (4),
    .PROG_DEPTH    (16),
    .ADDR_W        (4),
    .REPEAT_WIDTH  (8),
    .NOP_CMD       (4'd0),
    .TIMEOUT_CYCLES(10)
  ) dut (
    .CLK               (CLK),
    .RST               (RST),
    .prog_we           (prog_we),
    .prog_addr         (prog_addr),
    .prog_data         (prog_data),
    .prog_len          (prog_len),
    .start             (start),
    .array_ready       (array_ready),
    .command_to_execute(command_to_execute),
    .shift_direction   (shift_direction),
    .array_ack         (array_ack),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .step_idx          (step_idx)
  );

  typedef struct packed {
    logic       rdy;
    logic [3:0] cmd;
    logic [1:0] dir;
    logic       ack, bsy, dn, err;
    logic [3:0] idx;
  } exp_t;

  exp_t trace[$];
  exp_t cur;
  logic chk_on = 1'b0;
  int total = 0, bad = 0;

  logic [3:0] m_cmd [16];
  logic [1:0] m_dir [16];
  int         m_rep [16];
  int         last_idx = 0;
  logic       m_err = 1'b0;

  int cyc = 0, ack_cnt = 0, done_cyc = -1, fetch_cyc = -1;
  logic prev_busy = 1'b0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(posedge CLK) begin
    #1;
    cyc++;
    if (array_ack) ack_cnt++;
    if (done) done_cyc = cyc;
    if (busy && !prev_busy) fetch_cyc = cyc;
    prev_busy = busy;
  end

  // Single compare process against the trace model.
  always @(negedge CLK) begin
    #1;
    if (chk_on) begin
      check("cmd",      command_to_execute, cur.cmd);
      check("dir",      shift_direction,    cur.dir);
      check("ack",      array_ack,          cur.ack);
      check("busy",     busy,               cur.bsy);
      check("done",     done,               cur.dn);
      check("error",    error,              cur.err);
      check("step_idx", step_idx,           cur.idx);
    end
  end

  function automatic exp_t mk(input logic r, input logic [3:0] c, input logic [1:0] d,
                              input logic a, input logic b, input logic dn, input int i);
    exp_t e;
    e.rdy = r; e.cmd = c; e.dir = d; e.ack = a; e.bsy = b; e.dn = dn;
    e.err = m_err; e.idx = i[3:0];
    return e;
  endfunction

  // dly=0: ready tied high; dly>0: ready pulses dly cycles after each ISSUE.
  task automatic build_trace(input int len, input int dly);
    int n, w;
    logic tied;
    tied = (dly == 0);
    w = tied ? 1 : dly;
    m_err = 1'b0;
    trace.delete();
    n = (len > 16) ? 16 : len;
    for (int s = 0; s < n; s++) begin
      trace.push_back(mk(tied, 4'd0, 2'd0, 1'b0, 1'b1, 1'b0, s));
      for (int r = 0; r <= m_rep[s]; r++) begin
        trace.push_back(mk(tied, m_cmd[s], m_dir[s], 1'b0, 1'b1, 1'b0, s));
        for (int k = 0; k < w; k++)
          trace.push_back(mk(tied || (k == w - 1), m_cmd[s], m_dir[s], 1'b0, 1'b1, 1'b0, s));
        trace.push_back(mk(tied, 4'd0, 2'd0, 1'b1, 1'b1, 1'b0, s));
      end
    end
    if (n > 0) last_idx = n - 1;
    trace.push_back(mk(tied, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1, last_idx));
    trace.push_back(mk(tied, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, last_idx));
  endtask

  task automatic drive(input int len, input exp_t idle_e, input int poke_at, input int abort_at);
    @(negedge CLK);
    prog_len = 5'(len); start = 1'b1; array_ready = idle_e.rdy;
    cur = idle_e; chk_on = 1'b1;
    for (int i = 0; i < trace.size(); i++) begin
      @(negedge CLK);
      start = 1'b0; prog_we = 1'b0; array_ready = trace[i].rdy; cur = trace[i];
      if (i == poke_at) begin
        start = 1'b1; prog_we = 1'b1; prog_addr = 4'd0; prog_data = {4'hF, 2'd3, 8'd7};
      end
      if (i == abort_at) begin
        #3;
        chk_on = 1'b0; RST = 1'b1;
        #1;
        check("rst_cmd",  command_to_execute, 0);
        check("rst_dir",  shift_direction,    0);
        check("rst_ack",  array_ack,          0);
        check("rst_busy", busy,               0);
        check("rst_done", done,               0);
        check("rst_idx",  step_idx,           0);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0; array_ready = 1'b0; last_idx = 0; m_err = 1'b0;
        break;
      end
    end
    @(negedge CLK);
    chk_on = 1'b0; start = 1'b0; prog_we = 1'b0;
  endtask

  task automatic run_prog(input int len, input int dly, input int poke_at, input int abort_at);
    exp_t idle_e;
    idle_e = mk(dly == 0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, last_idx);
    build_trace(len, dly);
    drive(len, idle_e, poke_at, abort_at);
  endtask

  task automatic load(input int a, input logic [3:0] c, input logic [1:0] d, input int r);
    @(negedge CLK);
    prog_we = 1'b1; prog_addr = a[3:0]; prog_data = {c, d, 8'(r)};
    m_cmd[a] = c; m_dir[a] = d; m_rep[a] = r;
    @(negedge CLK);
    prog_we = 1'b0;
  endtask

  int a0, d0;

  initial begin
    RST = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_len = '0;
    start = 1'b0; array_ready = 1'b0;
    repeat (2) @(negedge CLK);
    check("reset_cmd",  command_to_execute, 0);
    check("reset_dir",  shift_direction,    0);
    check("reset_ack",  array_ack,          0);
    check("reset_busy", busy,               0);
    check("reset_done", done,               0);
    check("reset_err",  error,              0);
    check("reset_idx",  step_idx,           0);
    RST = 1'b0;

    // Single step, immediate ready.
    load(0, 4'd3, 2'd1, 0);
    a0 = ack_cnt;
    run_prog(1, 0, -1, -1);
    check("t1_acks", ack_cnt - a0, 1);
    check("t1_done_latency", done_cyc - fetch_cyc, 4);

    // Repeated step.
    load(0, 4'd5, 2'd2, 2);
    a0 = ack_cnt;
    run_prog(1, 0, -1, -1);
    check("t2_acks", ack_cnt - a0, 3);

    // Three steps with ready 5 cycles after each ISSUE.
    load(0, 4'd1, 2'd1, 0);
    load(1, 4'd2, 2'd2, 0);
    load(2, 4'd3, 2'd3, 0);
    a0 = ack_cnt;
    run_prog(3, 5, -1, -1);
    check("t3_acks", ack_cnt - a0, 3);

    // Empty program.
    a0 = ack_cnt;
    run_prog(0, 0, -1, -1);
    check("t4_acks", ack_cnt - a0, 0);

    // Start and store write while busy are ignored; rerun proves the store is unchanged.
    run_prog(3, 5, 4, -1);
    run_prog(3, 0, -1, -1);

    // Reset during WAIT_RDY of step 1, then rerun from step 0.
    run_prog(3, 5, -1, 11);
    a0 = ack_cnt;
    run_prog(3, 0, -1, -1);
    check("t5_acks", ack_cnt - a0, 3);

    // All-ones repeat must not spill into the next step.
    load(0, 4'd6, 2'd1, 255);
    load(1, 4'd7, 2'd2, 0);
    a0 = ack_cnt;
    run_prog(2, 0, -1, -1);
    check("t6_acks", ack_cnt - a0, 257);

    // Length beyond depth is clamped.
    for (int i = 0; i < 16; i++) load(i, 4'(i), 2'(i), 0);
    a0 = ack_cnt;
    run_prog(31, 0, -1, -1);
    check("t7_acks", ack_cnt - a0, 16);
    check("t7_last_idx", step_idx, 15);

`ifdef PE_SEQ_WATCHDOG_EN
    begin
      exp_t idle_e;
      load(0, 4'd9, 2'd1, 0);
      idle_e = mk(1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, last_idx);
      m_err = 1'b0;
      trace.delete();
      trace.push_back(mk(1'b0, 4'd0, 2'd0, 1'b0, 1'b1, 1'b0, 0));
      for (int k = 0; k < 11; k++) trace.push_back(mk(1'b0, 4'd9, 2'd1, 1'b0, 1'b1, 1'b0, 0));
      m_err = 1'b1;
      trace.push_back(mk(1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 0));
      trace.push_back(mk(1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 0));
      last_idx = 0;
      a0 = ack_cnt; d0 = done_cyc;
      drive(1, idle_e, -1, -1);
      check("wd_acks", ack_cnt - a0, 0);
      check("wd_no_done", done_cyc, d0);
      check("wd_error", error, 1);
      run_prog(1, 0, -1, -1);
      check("wd_cleared", error, 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
